// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage.
// Issues one data-memory bus transaction per aligned load or store.
// Aligns and extends the load data.
// Raises misalignment, bus-error and timeout exceptions.
// Stalls the upstream pipeline while a transaction is outstanding.
// exception_o[5] is the exception flag; exception_o[4:0] is the cause code.
module memory_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  input  logic [5:0]  exception_i,
  input  logic        flush_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_err_i,
  output logic [31:0] mem_data_o,
  output logic [5:0]  exception_o,
  output logic        stall_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [5:0] EXC_FLAG        = 6'b100000;
  localparam logic [5:0] CAUSE_LD_ALIGN  = 6'd4;
  localparam logic [5:0] CAUSE_LD_FAULT  = 6'd5;
  localparam logic [5:0] CAUSE_ST_ALIGN  = 6'd6;
  localparam logic [5:0] CAUSE_ST_FAULT  = 6'd7;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Byte-lane enables for the access size at the given byte offset.
  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the LSB-aligned store data across every lane it may land in.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{data[7:0]}};
      2'b01:   w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] rdata,
                                              input logic [1:0] off);
    logic [31:0] lane;
    logic [31:0] ext;
    lane = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ext = {24'd0, lane[7:0]};
      3'b101:  ext = {16'd0, lane[15:0]};
      default: ext = lane;
    endcase
    return ext;
  endfunction

  // A halfword must sit on an even address; a word must sit on a multiple of four.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

  logic [1:0]       state_q, state_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             is_load_q, is_load_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       off_q, off_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      res_q, res_d;
  logic [5:0]       exc_q, exc_d;

  logic mem_op;
  logic misaligned;
  logic [5:0] fault_exc;

  assign mem_op     = valid_i & (is_load_i | is_store_i) & ~flush_i & ~exception_i[5];
  assign misaligned = is_misaligned(funct3_i, addr_i[1:0]);
  assign fault_exc  = EXC_FLAG | (is_load_q ? CAUSE_LD_FAULT : CAUSE_ST_FAULT);

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;

  // Next-state, bus-register and output decode for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    is_load_d   = is_load_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    exc_d       = exc_q;
    stall_o     = 1'b0;
    exception_o = exception_i;
    mem_data_o  = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          if (misaligned) begin
            exception_o = EXC_FLAG | (is_load_i ? CAUSE_LD_ALIGN : CAUSE_ST_ALIGN);
          end else begin
            stall_o   = 1'b1;
            state_d   = S_REQ;
            req_d     = 1'b1;
            we_d      = is_store_i & ~is_load_i;
            addr_d    = {addr_i[31:2], 2'b00};
            be_d      = byte_enables(funct3_i, addr_i[1:0]);
            wdata_d   = store_lanes(funct3_i, store_data_i);
            is_load_d = is_load_i;
            funct3_d  = funct3_i;
            off_d     = addr_i[1:0];
            cnt_d     = '0;
            exc_d     = exception_i;
          end
        end
      end

      S_REQ: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (flush_i) begin
          // A killed access still has to finish on the bus; only its result is dropped.
          stall_o = 1'b0;
          if (dmem_ack_i) begin
            req_d   = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (dmem_ack_i) begin
          req_d   = 1'b0;
          state_d = S_DONE;
          if (dmem_err_i) begin
            exc_d = fault_exc;
            res_d = 32'd0;
          end else begin
            res_d = is_load_q ? load_extend(funct3_q, dmem_rdata_i, off_q) : 32'd0;
          end
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          state_d = S_DONE;
          exc_d   = fault_exc;
          res_d   = 32'd0;
        end
      end

      S_DONE: begin
        // Writeback samples at the end of this cycle; the input is not looked at here.
        if (!flush_i) begin
          exception_o = exc_q;
          mem_data_o  = res_q;
        end
        state_d = S_IDLE;
      end

      default: begin
        // S_DRAIN: a newly arriving memory op must wait for the bus to go idle.
        stall_o = mem_op;
        if (dmem_ack_i) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Stage registers; reset abandons any access that is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      be_q      <= 4'd0;
      wdata_q   <= 32'd0;
      is_load_q <= 1'b0;
      funct3_q  <= 3'd0;
      off_q     <= 2'd0;
      cnt_q     <= '0;
      res_q     <= 32'd0;
      exc_q     <= 6'd0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      is_load_q <= is_load_d;
      funct3_q  <= funct3_d;
      off_q     <= off_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      exc_q     <= exc_d;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed and randomized checks of memory_stage against a
// behavioural model written in plain arithmetic.
module tb_memory_stage;

  localparam int T = 16;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic        is_load_i;
  logic        is_store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] store_data_i;
  logic [5:0]  exception_i;
  logic        flush_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        dmem_err_i;
  logic [31:0] mem_data_o;
  logic [5:0]  exception_o;
  logic        stall_o;

  int tests;
  int fails;

  memory_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .is_load_i(is_load_i),
    .is_store_i(is_store_i), .funct3_i(funct3_i), .addr_i(addr_i),
    .store_data_i(store_data_i), .exception_i(exception_i), .flush_i(flush_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
    .dmem_rdata_i(dmem_rdata_i), .dmem_err_i(dmem_err_i), .mem_data_o(mem_data_o),
    .exception_o(exception_o), .stall_o(stall_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic int op_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
    int m;
    m = ((1 << op_size(f3)) - 1) << (addr % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
    int sz;
    sz = op_size(f3);
    if (sz == 1) return (sd & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int sz;
    longint v;
    longint span;
    sz = op_size(f3);
    v  = longint'(rdata) >> (8 * (addr % 4));
    if (sz < 4) begin
      span = longint'(1) << (8 * sz);
      v = v % span;
      if (!f3[2] && v >= span / 2) v = v - span;
    end
    return v[31:0];
  endfunction

  // One EX-stage instruction from presentation to the cycle after its result.
  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [5:0] exc, input int waits,
                        input logic [31:0] rdata, input bit err, input bit tmo);
    int sz;
    int stalls;
    int iters;
    bit memop;
    bit mis;
    logic [5:0] exp_exc;
    logic [31:0] exp_data;
    sz    = op_size(f3);
    memop = (ld || st) && !exc[5];
    mis   = (addr % sz) != 0;
    @(posedge clk); #1;
    valid_i = 1'b1; is_load_i = ld; is_store_i = st; funct3_i = f3;
    addr_i = addr; store_data_i = sd; exception_i = exc; flush_i = 1'b0;
    dmem_ack_i = 1'b0; dmem_err_i = 1'b0;
    @(negedge clk);
    if (!memop || mis) begin
      exp_exc = !memop ? exc : (ld ? 6'h24 : 6'h26);
      check("idle_stall", 32'(stall_o), 32'd0);
      check("idle_req", 32'(dmem_req_o), 32'd0);
      check("idle_exc", 32'(exception_o), 32'(exp_exc));
      check("idle_data", mem_data_o, 32'd0);
    end else begin
      stalls = stall_o ? 1 : 0;
      iters  = tmo ? T : waits + 1;
      for (int c = 0; c < iters; c++) begin
        @(posedge clk); #1;
        dmem_rdata_i = $urandom;
        if (!tmo && c == waits) begin
          dmem_ack_i = 1'b1; dmem_rdata_i = rdata; dmem_err_i = err;
        end
        @(negedge clk);
        if (stall_o) stalls++;
        check("req", 32'(dmem_req_o), 32'd1);
        check("we", 32'(dmem_we_o), 32'(st && !ld));
        check("addr", dmem_addr_o, addr & 32'hFFFF_FFFC);
        check("be", 32'(dmem_be_o), 32'(ref_be(f3, addr)));
        check("wdata", dmem_wdata_o, ref_wdata(f3, sd));
      end
      @(posedge clk); #1;
      dmem_ack_i = 1'b0; dmem_err_i = 1'b0; dmem_rdata_i = $urandom;
      @(negedge clk);
      exp_exc  = (err || tmo) ? (ld ? 6'h25 : 6'h27) : exc;
      exp_data = (ld && !err && !tmo) ? ref_load(f3, addr, rdata) : 32'd0;
      check("done_stall", 32'(stall_o), 32'd0);
      check("done_req", 32'(dmem_req_o), 32'd0);
      check("done_data", mem_data_o, exp_data);
      check("done_exc", 32'(exception_o), 32'(exp_exc));
      check("stall_cycles", 32'(stalls), 32'(iters + 1));
    end
    @(posedge clk); #1;
    valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
  endtask

  logic [2:0] f3_tab [5];

  initial begin
    tests = 0; fails = 0;
    f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
    f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;

    // reset state
    rst_n = 1'b0; valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
    funct3_i = 3'd0; addr_i = 32'd0; store_data_i = 32'd0; exception_i = 6'h15;
    flush_i = 1'b0; dmem_ack_i = 1'b0; dmem_rdata_i = 32'd0; dmem_err_i = 1'b0;
    #12;
    check("rst_req", 32'(dmem_req_o), 32'd0);
    check("rst_we", 32'(dmem_we_o), 32'd0);
    check("rst_addr", dmem_addr_o, 32'd0);
    check("rst_be", 32'(dmem_be_o), 32'd0);
    check("rst_wdata", dmem_wdata_o, 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_data", mem_data_o, 32'd0);
    check("rst_exc", 32'(exception_o), 32'h15);
    @(negedge clk); rst_n = 1'b1;

    // LB at 0x103, zero-wait ack
    run_op(1, 0, 3'b000, 32'h103, 32'd0, 6'h00, 0, 32'h80AA_BBCC, 0, 0);
    // LHU at 0x202, three wait cycles
    run_op(1, 0, 3'b101, 32'h202, 32'd0, 6'h00, 3, 32'h8001_1234, 0, 0);
    // SB 0x5A at 0x301 carrying a non-excepting tag
    run_op(0, 1, 3'b000, 32'h301, 32'h1234_565A, 6'h03, 1, 32'd0, 0, 0);
    // LW at 0x302: misaligned, no request
    run_op(1, 0, 3'b010, 32'h302, 32'd0, 6'h00, 0, 32'd0, 0, 0);
    // SH at 0x201: misaligned store
    run_op(0, 1, 3'b001, 32'h201, 32'h0000_BEEF, 6'h00, 0, 32'd0, 0, 0);
    // SW with bus error
    run_op(0, 1, 3'b010, 32'h40C, 32'hDEAD_BEEF, 6'h00, 2, 32'd0, 1, 0);
    // LW with no ack: timeout
    run_op(1, 0, 3'b010, 32'h410, 32'd0, 6'h00, 0, 32'd0, 0, 1);
    // Already-excepting load and a non-memory instruction pass straight through
    run_op(1, 0, 3'b010, 32'h500, 32'd0, 6'h22, 0, 32'd0, 0, 0);
    run_op(0, 0, 3'b010, 32'h500, 32'd0, 6'h09, 0, 32'd0, 0, 0);

    // flush in the second REQ cycle, ack two cycles later, new LW waits in DRAIN
    @(posedge clk); #1;
    valid_i = 1'b1; is_load_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010;
    addr_i = 32'h400; exception_i = 6'h00; flush_i = 1'b0;
    @(negedge clk);
    check("fl_issue_stall", 32'(stall_o), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("fl_req1", 32'(dmem_req_o), 32'd1);
    @(posedge clk); #1; flush_i = 1'b1;
    @(negedge clk);
    check("fl_stall", 32'(stall_o), 32'd0);
    check("fl_req2", 32'(dmem_req_o), 32'd1);
    check("fl_data", mem_data_o, 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0; addr_i = 32'h500; exception_i = 6'h01;
    @(negedge clk);
    check("drain_stall", 32'(stall_o), 32'd1);
    check("drain_req", 32'(dmem_req_o), 32'd1);
    check("drain_addr", dmem_addr_o, 32'h400);
    @(posedge clk); #1;
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h1111_2222;
    @(negedge clk);
    check("drain_ack_stall", 32'(stall_o), 32'd1);
    check("drain_ack_data", mem_data_o, 32'd0);
    check("drain_ack_exc", 32'(exception_o), 32'h01);
    @(posedge clk); #1;
    dmem_ack_i = 1'b0; valid_i = 1'b0; is_load_i = 1'b0;
    @(negedge clk);
    check("post_drain_req", 32'(dmem_req_o), 32'd0);
    check("post_drain_data", mem_data_o, 32'd0);
    check("post_drain_exc", 32'(exception_o), 32'h01);
    run_op(1, 0, 3'b010, 32'h500, 32'd0, 6'h01, 0, 32'hCAFE_F00D, 0, 0);

    // reset asserted mid-REQ
    @(posedge clk); #1;
    valid_i = 1'b1; is_load_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h600;
    exception_i = 6'h00;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_req", 32'(dmem_req_o), 32'd1);
    #1; rst_n = 1'b0; valid_i = 1'b0; is_load_i = 1'b0;
    #1;
    check("mid_rst_req", 32'(dmem_req_o), 32'd0);
    check("mid_rst_addr", dmem_addr_o, 32'd0);
    check("mid_rst_stall", 32'(stall_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op(1, 0, 3'b010, 32'h604, 32'd0, 6'h00, 1, 32'h1357_9BDF, 0, 0);

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      bit ld;
      bit st;
      logic [2:0] f3;
      logic [5:0] exc;
      ld  = ($urandom_range(0, 1) == 1);
      st  = !ld && ($urandom_range(0, 9) != 0);
      f3  = ld ? f3_tab[$urandom_range(0, 4)] : f3_tab[$urandom_range(0, 2)];
      exc = 6'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) exc[5] = 1'b1;
      run_op(ld, st, f3, $urandom, $urandom, exc, $urandom_range(0, 3), $urandom,
             ($urandom_range(0, 7) == 0), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
